// File: rtl/dmem_arbiter.sv
// Arbiter that shares the single-ported data memory between the MEM stage and an
// external valid/ready master. The core has priority, and a wait counter bounds how long the external master can be starved.
module dmem_arbiter #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [XLEN/8-1:0]     core_be,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [XLEN-1:0]       core_wd,
  output logic [XLEN-1:0]       core_rd,
  output logic                  core_stall,
  input  logic                  ext_valid,
  output logic                  ext_ready,
  input  logic                  ext_we,
  input  logic [XLEN/8-1:0]     ext_be,
  input  logic [ADDR_WIDTH-1:0] ext_addr,
  input  logic [XLEN-1:0]       ext_wd,
  output logic                  ext_rvalid,
  output logic [XLEN-1:0]       ext_rdata,
  output logic                  mem_we,
  output logic [XLEN/8-1:0]     mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]       mem_wd,
  input  logic [XLEN-1:0]       mem_rd
);

  localparam int         NB    = XLEN / 8;
  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  logic [3:0]      wait_cnt_q, wait_cnt_d;
  logic            ext_rvalid_q, ext_rvalid_d;
  logic [XLEN-1:0] ext_rdata_q, ext_rdata_d;
  logic            starve, grant_ext, grant_core;

  // Grants are qualified by rst_n so nothing reaches memory while reset is held.
  assign starve     = (wait_cnt_q == MAX_W);
  assign grant_ext  = rst_n & ext_valid & (~core_req | starve);
  assign grant_core = rst_n & core_req & ~grant_ext;

  assign ext_ready  = grant_ext;
  assign core_stall = core_req & grant_ext;
  assign core_rd    = mem_rd;
  assign ext_rvalid = ext_rvalid_q;
  assign ext_rdata  = ext_rdata_q;

  always_comb begin
    mem_we   = 1'b0;
    mem_be   = '0;
    mem_addr = core_addr;
    mem_wd   = core_wd;
    if (grant_ext) begin
      mem_we   = ext_we;
      mem_be   = ext_be;
      mem_addr = ext_addr;
      mem_wd   = ext_wd;
    end else if (grant_core) begin
      mem_we = core_we;
      mem_be = core_be;
    end
  end

  always_comb begin
    wait_cnt_d   = wait_cnt_q;
    ext_rvalid_d = grant_ext & ~ext_we;
    ext_rdata_d  = ext_rdata_q;
    if (grant_ext || !ext_valid)
      wait_cnt_d = '0;
    else if (!starve)
      wait_cnt_d = wait_cnt_q + 4'd1;
    if (grant_ext && !ext_we)
      ext_rdata_d = mem_rd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q   <= '0;
      ext_rvalid_q <= 1'b0;
      ext_rdata_q  <= '0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      ext_rvalid_q <= ext_rvalid_d;
      ext_rdata_q  <= ext_rdata_d;
    end
  end

  logic unused_nb;
  assign unused_nb = (NB == 0);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized run against a
// cycle-level reference model of the arbitration rules and memory contents.
module tb_dmem_arbiter;
  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req, core_we, core_stall;
  logic [3:0]  core_be;
  logic [7:0]  core_addr;
  logic [31:0] core_wd, core_rd;
  logic        ext_valid, ext_ready, ext_we, ext_rvalid;
  logic [3:0]  ext_be;
  logic [7:0]  ext_addr;
  logic [31:0] ext_wd, ext_rdata;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wd, mem_rd;

  int checks = 0;
  int errors = 0;

  logic [31:0] dmem [64];

  always #5 clk = ~clk;

  assign mem_rd = dmem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) dmem[mem_addr[7:2]][8*b +: 8] <= mem_wd[8*b +: 8];
  end

  dmem_arbiter #(.XLEN(32), .ADDR_WIDTH(8), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_be(core_be),
    .core_addr(core_addr), .core_wd(core_wd), .core_rd(core_rd),
    .core_stall(core_stall),
    .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_we(ext_we),
    .ext_be(ext_be), .ext_addr(ext_addr), .ext_wd(ext_wd),
    .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  task automatic adv();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_core(input logic r, input logic w, input logic [3:0] be,
                            input logic [7:0] a, input logic [31:0] d);
    core_req = r; core_we = w; core_be = be; core_addr = a; core_wd = d;
  endtask

  task automatic drive_ext(input logic v, input logic w, input logic [3:0] be,
                           input logic [7:0] a, input logic [31:0] d);
    ext_valid = v; ext_we = w; ext_be = be; ext_addr = a; ext_wd = d;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    drive_core(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    drive_ext(1'b1, 1'b1, 4'hF, 8'h08, 32'hCAFEF00D);
    #3;
    checks++; if (ext_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %0b exp 0", ext_ready); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %0b exp 0", mem_we); end
    checks++; if (ext_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %0b exp 0", ext_rvalid); end
    checks++; if (ext_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", ext_rdata); end
    adv();
    rst_n = 1'b1;
    #1;
    checks++; if (ext_ready !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL rst_first_accept got ready=%0b we=%0b exp 1 1", ext_ready, mem_we); end
    adv();
    drive_ext(1'b1, 1'b0, 4'hF, 8'h08, 32'h0);
    #1;
    checks++; if (ext_ready !== 1'b1) begin errors++; $display("FAIL rst_rd_accept got %0b exp 1", ext_ready); end
    adv();
    drive_ext(1'b1, 1'b0, 4'hF, 8'h08, 32'h0);
    #1;
    checks++; if (ext_rvalid !== 1'b1 || ext_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL rst_pre_rdata got %0b %h exp 1 cafef00d", ext_rvalid, ext_rdata); end
    checks++; if (ext_ready !== 1'b1) begin errors++; $display("FAIL rst_inflight_accept got %0b exp 1", ext_ready); end
    rst_n = 1'b0;
    #1;
    checks++; if (ext_ready !== 1'b0 || ext_rvalid !== 1'b0 || ext_rdata !== 32'h0) begin errors++; $display("FAIL rst_mid got ready=%0b rv=%0b rd=%h exp 0 0 0", ext_ready, ext_rvalid, ext_rdata); end
    drive_core(1'b1, 1'b1, 4'hF, 8'h08, 32'h0);
    #1;
    checks++; if (mem_we !== 1'b0 || mem_be !== 4'h0 || core_stall !== 1'b0) begin errors++; $display("FAIL rst_mid_gate got we=%0b be=%h stall=%0b exp 0 0 0", mem_we, mem_be, core_stall); end
    adv();
    checks++; if (ext_rvalid !== 1'b0) begin errors++; $display("FAIL rst_inflight_rvalid got %0b exp 0", ext_rvalid); end
    drive_core(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    rst_n = 1'b1;
    #1;
    checks++; if (ext_ready !== 1'b1) begin errors++; $display("FAIL rst_release_accept got %0b exp 1", ext_ready); end
    adv();
    drive_ext(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    #1;
    checks++; if (ext_rvalid !== 1'b1 || ext_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL rst_release_rdata got %0b %h exp 1 cafef00d", ext_rvalid, ext_rdata); end
    adv();
  endtask

  task automatic test_core_only();
    drive_ext(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    drive_core(1'b1, 1'b1, 4'hF, 8'h10, 32'hDEADBEEF);
    #1;
    checks++; if (mem_we !== 1'b1 || mem_be !== 4'hF || mem_addr !== 8'h10 || core_stall !== 1'b0) begin errors++; $display("FAIL core_store got we=%0b be=%h a=%h stall=%0b exp 1 f 10 0", mem_we, mem_be, mem_addr, core_stall); end
    adv();
    drive_core(1'b1, 1'b0, 4'hF, 8'h10, 32'h0);
    #1;
    checks++; if (mem_we !== 1'b0 || core_rd !== 32'hDEADBEEF || core_stall !== 1'b0) begin errors++; $display("FAIL core_load got we=%0b rd=%h stall=%0b exp 0 deadbeef 0", mem_we, core_rd, core_stall); end
    adv();
    drive_core(1'b0, 1'b1, 4'hF, 8'h10, 32'h0);
    #1;
    checks++; if (mem_we !== 1'b0 || mem_be !== 4'h0) begin errors++; $display("FAIL core_idle got we=%0b be=%h exp 0 0", mem_we, mem_be); end
    adv();
  endtask

  task automatic test_ext_only();
    drive_core(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    drive_ext(1'b1, 1'b1, 4'hF, 8'h20, 32'h12345678);
    #1;
    checks++; if (ext_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h20) begin errors++; $display("FAIL ext_wr got ready=%0b we=%0b a=%h exp 1 1 20", ext_ready, mem_we, mem_addr); end
    adv();
    drive_ext(1'b1, 1'b0, 4'hF, 8'h20, 32'h0);
    #1;
    checks++; if (ext_rvalid !== 1'b0) begin errors++; $display("FAIL ext_wr_rvalid got %0b exp 0", ext_rvalid); end
    checks++; if (ext_ready !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL ext_rd got ready=%0b we=%0b exp 1 0", ext_ready, mem_we); end
    adv();
    drive_ext(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    #1;
    checks++; if (ext_rvalid !== 1'b1 || ext_rdata !== 32'h12345678) begin errors++; $display("FAIL ext_rdata got %0b %h exp 1 12345678", ext_rvalid, ext_rdata); end
    adv();
    checks++; if (ext_rvalid !== 1'b0 || ext_rdata !== 32'h12345678) begin errors++; $display("FAIL ext_rdata_hold got %0b %h exp 0 12345678", ext_rvalid, ext_rdata); end
  endtask

  task automatic test_starvation();
    bit exp;
    drive_core(1'b1, 1'b0, 4'hF, 8'h10, 32'h0);
    drive_ext(1'b1, 1'b1, 4'hF, 8'h30, 32'h000055AA);
    for (int i = 0; i < 10; i++) begin
      #1;
      exp = (i == MW) || (i == 2*MW + 1);
      checks++; if (ext_ready !== exp || core_stall !== exp || mem_we !== exp) begin errors++; $display("FAIL starve_c%0d got ready=%0b stall=%0b we=%0b exp %0b", i, ext_ready, core_stall, mem_we, exp); end
      checks++; if (mem_addr !== (exp ? 8'h30 : 8'h10)) begin errors++; $display("FAIL starve_addr_c%0d got %h exp %h", i, mem_addr, exp ? 8'h30 : 8'h10); end
      adv();
    end
    drive_core(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    drive_ext(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    adv();
  endtask

  task automatic test_withdraw();
    drive_core(1'b1, 1'b0, 4'hF, 8'h10, 32'h0);
    drive_ext(1'b1, 1'b0, 4'hF, 8'h20, 32'h0);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (ext_ready !== 1'b0 || ext_rvalid !== 1'b0) begin errors++; $display("FAIL wd_denied_c%0d got ready=%0b rv=%0b exp 0 0", i, ext_ready, ext_rvalid); end
      adv();
    end
    ext_valid = 1'b0;
    #1;
    checks++; if (ext_ready !== 1'b0 || mem_addr !== 8'h10 || ext_rvalid !== 1'b0) begin errors++; $display("FAIL wd_drop got ready=%0b a=%h rv=%0b exp 0 10 0", ext_ready, mem_addr, ext_rvalid); end
    adv();
    ext_valid = 1'b1;
    for (int i = 0; i <= MW; i++) begin
      #1;
      checks++; if (ext_ready !== (i == MW) || ext_rvalid !== 1'b0) begin errors++; $display("FAIL wd_reassert_c%0d got ready=%0b rv=%0b exp %0b 0", i, ext_ready, ext_rvalid, i == MW); end
      adv();
    end
    drive_ext(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    drive_core(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    #1;
    checks++; if (ext_rvalid !== 1'b1 || ext_rdata !== 32'h12345678) begin errors++; $display("FAIL wd_final_rdata got %0b %h exp 1 12345678", ext_rvalid, ext_rdata); end
    adv();
  endtask

  task automatic test_byte_lane();
    drive_core(1'b1, 1'b1, 4'hF, 8'h40, 32'h11223344);
    adv();
    drive_core(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    drive_ext(1'b1, 1'b1, 4'h2, 8'h40, 32'h0000AB00);
    #1;
    checks++; if (mem_be !== 4'h2 || mem_wd !== 32'h0000AB00) begin errors++; $display("FAIL byte_wr got be=%h wd=%h exp 2 0000ab00", mem_be, mem_wd); end
    adv();
    drive_ext(1'b1, 1'b0, 4'hF, 8'h40, 32'h0);
    adv();
    drive_ext(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    #1;
    checks++; if (ext_rvalid !== 1'b1 || ext_rdata !== 32'h1122AB44) begin errors++; $display("FAIL byte_rd got %0b %h exp 1 1122ab44", ext_rvalid, ext_rdata); end
    adv();
  endtask

  task automatic test_back_to_back();
    logic [7:0]  addrs [3];
    logic [31:0] exps  [3];
    addrs[0] = 8'h10; addrs[1] = 8'h20; addrs[2] = 8'h40;
    exps[0]  = 32'hDEADBEEF; exps[1] = 32'h12345678; exps[2] = 32'h1122AB44;
    drive_core(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive_ext(1'b1, 1'b0, 4'hF, addrs[i], 32'h0);
      else       drive_ext(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
      #1;
      if (i < 3) begin
        checks++; if (ext_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d got %0b exp 1", i, ext_ready); end
      end
      if (i > 0) begin
        checks++; if (ext_rvalid !== 1'b1 || ext_rdata !== exps[i-1]) begin errors++; $display("FAIL b2b_rdata_%0d got %0b %h exp 1 %h", i, ext_rvalid, ext_rdata, exps[i-1]); end
      end
      adv();
    end
  endtask

  task automatic test_random();
    logic [31:0] ref_mem [64];
    int          wcnt, stall_run;
    bit          exp_rv, pend, gext, gcore, exp_we;
    logic [31:0] exp_rd;
    logic [3:0]  exp_be;
    logic [7:0]  exp_addr;
    rst_n = 1'b0;
    drive_core(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    drive_ext(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    adv();
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = $urandom;
      drive_core(1'b1, 1'b1, 4'hF, 8'(i * 4), ref_mem[i]);
      adv();
    end
    wcnt = 0; stall_run = 0; exp_rv = 0; exp_rd = 32'h0; pend = 0;
    for (int c = 0; c < 600; c++) begin
      drive_core(($urandom % 4) != 0, 1'($urandom), 4'($urandom), 8'($urandom), $urandom);
      if (!pend) drive_ext(1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom), $urandom);
      else if ($urandom % 10 == 0) ext_valid = 1'b0;
      #1;
      gext  = ext_valid && (!core_req || wcnt == MW);
      gcore = core_req && !gext;
      exp_we   = gext ? ext_we : (gcore && core_we);
      exp_be   = gext ? ext_be : (gcore ? core_be : 4'h0);
      exp_addr = gext ? ext_addr : core_addr;
      checks++; if (ext_ready !== gext || core_stall !== (core_req && gext)) begin errors++; $display("FAIL rnd_grant_c%0d got ready=%0b stall=%0b exp %0b %0b", c, ext_ready, core_stall, gext, core_req && gext); end
      checks++; if (mem_we !== exp_we || mem_be !== exp_be || mem_addr !== exp_addr) begin errors++; $display("FAIL rnd_mem_c%0d got we=%0b be=%h a=%h exp %0b %h %h", c, mem_we, mem_be, mem_addr, exp_we, exp_be, exp_addr); end
      checks++; if (ext_rvalid !== exp_rv || ext_rdata !== exp_rd) begin errors++; $display("FAIL rnd_rdata_c%0d got %0b %h exp %0b %h", c, ext_rvalid, ext_rdata, exp_rv, exp_rd); end
      if (gcore && !core_we) begin
        checks++; if (core_rd !== ref_mem[core_addr[7:2]]) begin errors++; $display("FAIL rnd_core_rd_c%0d got %h exp %h", c, core_rd, ref_mem[core_addr[7:2]]); end
      end
      stall_run = (core_req && gext) ? stall_run + 1 : 0;
      if (stall_run > 1) begin
        checks++; errors++; $display("FAIL rnd_stall_run_c%0d got %0d exp <=1", c, stall_run);
      end
      if (gext && !ext_we) exp_rd = ref_mem[ext_addr[7:2]];
      exp_rv = gext && !ext_we;
      if (gext && ext_we) ref_mem[ext_addr[7:2]] = merge(ref_mem[ext_addr[7:2]], ext_wd, ext_be);
      else if (gcore && core_we) ref_mem[core_addr[7:2]] = merge(ref_mem[core_addr[7:2]], core_wd, core_be);
      if (gext || !ext_valid) wcnt = 0;
      else if (wcnt < MW) wcnt++;
      pend = ext_valid && !gext;
      adv();
    end
  endtask

  initial begin
    test_reset();
    test_core_only();
    test_ext_only();
    test_starvation();
    test_withdraw();
    test_byte_lane();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
